spi_slave_regbank: RTL and testbench
====================================

Name: spi_slave_regbank

Overview:
- SPI responder (slave end) with an internal register bank, oversampled in the system clock domain.
- Decodes a command byte (R/W + address), then writes or reads back data bytes MSB-first, with auto-incrementing burst.
- Supports all four SPI modes.
- Sits on the external SPI pins of a peripheral and exposes the register contents and write strobes to the local logic.

Parameters:
- DATA_W, 8, bits per SPI byte and per register.
- NUM_REGS, 8, number of registers in the bank (power of two, max 128).
- ADDR_W, 3, register index width (log2 NUM_REGS).
- SYNC_STAGES, 2, synchroniser depth on sclk, cs_n and mosi.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MODE  input  2  SPI mode: MODE[1]=CPOL, MODE[0]=CPHA.
- sclk  input  1  SPI clock from master (asynchronous to clk).
- cs_n  input  1  chip select, active low.
- mosi  input  1  master-out serial data.
- miso  output  1  slave-out serial data.
- miso_oe  output  1  high while selected; drives the external tristate.
- regs_flat  output  NUM_REGS*DATA_W  register bank; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_pulse  output  1  one-clk strobe when a register is written.
- wr_addr  output  ADDR_W  index written; valid with wr_pulse.
- frame_done  output  1  one-clk strobe on a clean frame end.
- frame_err  output  1  one-clk strobe on a frame aborted mid-byte.

Behaviour:
- Reset: all registers 0x00, miso=0, miso_oe=0, all strobes 0, FSM in IDLE, bit counter 0.
  - Reset asserted mid-frame discards the transaction.
  - After reset the block waits for cs_n high, then a fresh falling edge, before decoding.
- Synchronisation and edge detection:
  - sclk, cs_n and mosi pass through SYNC_STAGES flops.
  - Edges are detected from the synchronised sclk.
  - Minimum legal sclk high and low time is 4 clk periods.
- Mode latch: MODE is latched on the synchronised cs_n falling edge and held for the whole frame.
- Edge roles:
  - Leading edge is rising when CPOL=0, falling when CPOL=1.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- Shift order: MSB first on both mosi and miso. A 3-bit bit counter counts sample edges and wraps 7->0 at each byte boundary.
- FSM states: IDLE, CMD, WR_DATA, RD_DATA.
  - IDLE -> CMD on the cs_n falling edge; bit counter cleared.
  - CMD, after 8 samples: bit7=1 selects WR_DATA, bit7=0 selects RD_DATA. Bits[6:0] give the start address.
  - WR_DATA: on the 8th sample of each data byte, the register at the current address takes the byte. wr_pulse and wr_addr are asserted the following clk, then the address increments.
  - RD_DATA: at the 8th command sample, tx_reg is loaded with the register at the address, and the address increments.
    - miso = tx_reg MSB.
    - tx_reg shifts left on a shift edge only after at least one sample edge of the current data byte. This makes the first data-byte shift edge a no-op in CPHA=1.
    - After each 8th sample, tx_reg reloads from the next address.
  - Any state -> IDLE on the cs_n rising edge.
- Address wrap: the address wraps NUM_REGS-1 -> 0 during a burst.
- Out-of-range addresses: a start address >= NUM_REGS is invalid for the whole frame.
  - Writes are discarded with no wr_pulse.
  - Reads return 0x00.
  - No wrap occurs.
- miso:
  - 0 in IDLE, CMD and WR_DATA.
  - miso_oe = synchronised cs_n inverted.
- Frame end, on the cs_n rising edge:
  - Bit counter 0 with at least the command byte complete: frame_done pulses.
  - Bit counter nonzero: frame_err pulses and the partial byte is discarded with no write.
  - Command-only frame (0 data bytes): frame_done, no write.
- Simultaneous events:
  - A cs_n rise in the same clk as an 8th sample: the sample completes first (the write commits), then frame_done.
  - sclk edges while cs_n is high are ignored.

Test Plan:
- Mode 0, frame 0x83,0xA5 -> regs[3]=0xA5; one wr_pulse with wr_addr=3; frame_done once; frame_err never.
- Mode 3, after the above, frame 0x03 plus 8 dummy clocks -> miso bits 1,0,1,0,0,1,0,1 captured on master sample edges; no register change.
- Mode 1, burst 0x87,0x11,0x22,0x33 -> regs[7]=0x11, regs[0]=0x22, regs[1]=0x33; three wr_pulse with wr_addr 7,0,1.
- Mode 2, 0x82 then cs_n rises after 5 data bits -> regs[2] unchanged; no wr_pulse; frame_err=1 for one clk; the next full frame decodes normally.
- Invalid address: write 0x8A,0xFF -> no register change, no wr_pulse; read 0x0A -> miso returns 0x00.
- reset low mid-data-byte -> all regs 0x00, miso_oe=0; the frame completing after reset is ignored until cs_n toggles high then low.

Source files
------------

// File: rtl/spi_slave_regbank.sv
// SPI responder with a small register bank. The SPI pins are oversampled in
// the clk domain; a command byte (bit7 = write, bits[6:0] = start address)
// is followed by auto-incrementing data bytes, MSB first, in any SPI mode.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | deselected, or waiting for a fresh cs_n fall after reset
// S_CMD      | shifting in the command byte
// S_WR_DATA  | shifting in data bytes, committing each to the bank
// S_RD_DATA  | shifting out bank contents on miso
module spi_slave_regbank #(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 MODE,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       mosi,
    output logic                       miso,
    output logic                       miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_done,
    output logic                       frame_err
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR_DATA, S_RD_DATA} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev, armed_q;
    logic                   cpol_q, cpha_q;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]      rx_sh_q;
    logic [DATA_W-1:0]      tx_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   addr_bad_q;
    logic                   byte_sampled_q;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];

    logic              sclk_s, cs_s, mosi_s;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic              lead_edge, trail_edge, active;
    logic              sample_edge, shift_edge, last_bit, byte_done;
    logic              frame_end, cmd_done, frame_done_d, frame_err_d;
    logic [DATA_W-1:0] rx_byte;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_bad;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;

    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign active      = (state_q != S_IDLE);
    assign sample_edge = active & (cpha_q ? trail_edge : lead_edge);
    assign shift_edge  = active & (cpha_q ? lead_edge : trail_edge);
    assign last_bit    = (bit_cnt_q == LAST_BIT);
    assign byte_done   = sample_edge & last_bit;
    assign frame_end   = active & cs_rise;

    assign rx_byte  = {rx_sh_q, mosi_s};
    assign cmd_addr = rx_byte[ADDR_W-1:0];
    assign cmd_bad  = (int'(rx_byte[DATA_W-2:0]) >= NUM_REGS);

    // cs_n sync chain resets to "selected" so a select held across reset
    // never looks like a fresh falling edge; armed_q gates miso_oe until
    // cs_n has been seen high.
    assign miso_oe = armed_q & ~cs_s;
    assign miso    = (state_q == S_RD_DATA) ? tx_q[DATA_W-1] : 1'b0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    // Pin synchronisers and previous-value flops for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            armed_q   <= armed_q | cs_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bit count and frame-end strobes; a sample landing in the
    // same clk as the cs_n rise is counted before the frame is judged.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = sample_edge ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
        cmd_done     = (state_q == S_WR_DATA) || (state_q == S_RD_DATA) ||
                       ((state_q == S_CMD) && byte_done);
        frame_done_d = frame_end & cmd_done & (bit_cnt_d == '0);
        frame_err_d  = frame_end & (bit_cnt_d != '0);
        case (state_q)
            S_IDLE: if (cs_fall) state_d = S_CMD;
            S_CMD:  if (byte_done) state_d = rx_byte[DATA_W-1] ? S_WR_DATA : S_RD_DATA;
            default: ;
        endcase
        if (frame_end) state_d = S_IDLE;
    end

    // Shift registers, address pointer, register bank and strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpol_q         <= 1'b0;
            cpha_q         <= 1'b0;
            bit_cnt_q      <= '0;
            rx_sh_q        <= '0;
            tx_q           <= '0;
            addr_q         <= '0;
            addr_bad_q     <= 1'b0;
            byte_sampled_q <= 1'b0;
            wr_pulse       <= 1'b0;
            wr_addr        <= '0;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse   <= 1'b0;
            frame_done <= frame_done_d;
            frame_err  <= frame_err_d;
            if (!active) begin
                if (cs_fall) begin
                    cpol_q         <= MODE[1];
                    cpha_q         <= MODE[0];
                    bit_cnt_q      <= '0;
                    tx_q           <= '0;
                    addr_bad_q     <= 1'b0;
                    byte_sampled_q <= 1'b0;
                end
            end else begin
                bit_cnt_q <= frame_end ? '0 : bit_cnt_d;
                if (sample_edge) begin
                    rx_sh_q        <= rx_byte[DATA_W-2:0];
                    byte_sampled_q <= ~last_bit;
                end else if (shift_edge && byte_sampled_q && state_q == S_RD_DATA) begin
                    tx_q <= tx_q << 1;
                end
                if (byte_done) begin
                    case (state_q)
                        S_CMD: begin
                            addr_bad_q <= cmd_bad;
                            if (rx_byte[DATA_W-1]) begin
                                addr_q <= cmd_addr;
                            end else begin
                                tx_q   <= cmd_bad ? '0 : regs_q[cmd_addr];
                                addr_q <= cmd_bad ? cmd_addr : cmd_addr + ADDR_W'(1);
                            end
                        end
                        S_WR_DATA: begin
                            if (!addr_bad_q) begin
                                regs_q[addr_q] <= rx_byte;
                                wr_pulse       <= 1'b1;
                                wr_addr        <= addr_q;
                                addr_q         <= addr_q + ADDR_W'(1);
                            end
                        end
                        S_RD_DATA: begin
                            tx_q <= addr_bad_q ? '0 : regs_q[addr_q];
                            if (!addr_bad_q) addr_q <= addr_q + ADDR_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed and randomized frames against a byte-level model of the bank.
`timescale 1ns/1ps
module tb_spi_slave_regbank;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int H        = 80;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [1:0]                 mode;
    logic                       sclk, cs_n, mosi;
    logic                       miso, miso_oe, wr_pulse, frame_done, frame_err;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [ADDR_W-1:0]          wr_addr;

    spi_slave_regbank #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .MODE(mode), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .regs_flat(regs_flat),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_done(frame_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]        tx_buf[$];
    logic [7:0]        rx_buf[$];
    logic [7:0]        exp_regs[NUM_REGS];
    logic [ADDR_W-1:0] wr_log[$];
    int                exp_wr_addr[$];
    logic [7:0]        exp_rd[$];
    int                done_cnt = 0;
    int                err_cnt  = 0;

    // Event monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_pulse)   wr_log.push_back(wr_addr);
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[i*8 +: 8] = exp_regs[i];
        return v;
    endfunction

    // Master side: sends the first nbits of tx_buf, captures miso per byte.
    task automatic spi_frame(input logic [1:0] m, input int nbits);
        logic [7:0] cur;
        logic [7:0] acc;
        rx_buf.delete();
        acc  = '0;
        mode = m;
        sclk = m[1];
        mosi = 1'b0;
        #(4*H);
        cs_n = 1'b0;
        #(H);
        chk("sel/miso_oe", 64'(miso_oe), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            cur = tx_buf[i/8];
            if (!m[0]) begin
                mosi = cur[7-(i%8)];
                #(H);
                acc  = {acc[6:0], miso};
                sclk = ~m[1];
                #(H);
                sclk = m[1];
            end else begin
                sclk = ~m[1];
                mosi = cur[7-(i%8)];
                #(H);
                acc  = {acc[6:0], miso};
                sclk = m[1];
                #(H);
            end
            if (i % 8 == 7) rx_buf.push_back(acc);
        end
        #(H);
        cs_n = 1'b1;
        #(4*H);
    endtask

    // Builds expectations from the command byte, runs the frame, compares.
    task automatic run_frame(input string tag, input logic [1:0] m, input int nbits);
        int         nfull, a, wbase, dbase, ebase, idx;
        logic [7:0] cmd;
        exp_wr_addr.delete();
        exp_rd.delete();
        nfull = nbits / 8;
        cmd   = tx_buf[0];
        a     = int'(cmd[6:0]);
        for (int k = 1; k < nfull; k++) begin
            idx = (a + k - 1) % NUM_REGS;
            if (cmd[7]) begin
                if (a < NUM_REGS) begin
                    exp_regs[idx] = tx_buf[k];
                    exp_wr_addr.push_back(idx);
                end
            end else begin
                exp_rd.push_back((a < NUM_REGS) ? exp_regs[idx] : 8'h00);
            end
        end
        wbase = wr_log.size();
        dbase = done_cnt;
        ebase = err_cnt;
        spi_frame(m, nbits);
        chk({tag, "/regs"}, regs_flat, model_flat());
        chk({tag, "/wr_cnt"}, 64'(wr_log.size() - wbase), 64'(exp_wr_addr.size()));
        foreach (exp_wr_addr[i])
            if (wbase + i < wr_log.size())
                chk({tag, "/wr_addr"}, 64'(wr_log[wbase+i]), 64'(exp_wr_addr[i]));
        chk({tag, "/done"}, 64'(done_cnt - dbase), 64'((nbits % 8 == 0 && nfull >= 1) ? 1 : 0));
        chk({tag, "/err"}, 64'(err_cnt - ebase), 64'((nbits % 8 != 0) ? 1 : 0));
        if (!cmd[7] && nfull >= 1) begin
            chk({tag, "/miso_cmd"}, 64'(rx_buf[0]), 64'h0);
            foreach (exp_rd[i]) chk({tag, "/miso_data"}, 64'(rx_buf[i+1]), 64'(exp_rd[i]));
        end
    endtask

    initial begin
        int         wbase, dbase, ebase, len;
        logic [1:0] m;
        logic [7:0] cmd;

        reset = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        mode  = 2'b00;
        foreach (exp_regs[i]) exp_regs[i] = 8'h00;
        repeat (5) @(posedge clk);
        #2;
        chk("rst/regs", regs_flat, 64'h0);
        chk("rst/miso_oe", 64'(miso_oe), 64'h0);
        chk("rst/miso", 64'(miso), 64'h0);
        chk("rst/strobes", 64'({wr_pulse, frame_done, frame_err}), 64'h0);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("idle/miso_oe", 64'(miso_oe), 64'h0);

        tx_buf.delete(); tx_buf.push_back(8'h83); tx_buf.push_back(8'hA5);
        run_frame("m0_wr", 2'b00, 16);
        chk("m0/reg3", 64'(regs_flat[3*8 +: 8]), 64'hA5);

        tx_buf.delete(); tx_buf.push_back(8'h03); tx_buf.push_back(8'h00);
        run_frame("m3_rd", 2'b11, 16);
        chk("m3/miso_byte", 64'(rx_buf[1]), 64'hA5);

        tx_buf.delete();
        tx_buf.push_back(8'h87); tx_buf.push_back(8'h11);
        tx_buf.push_back(8'h22); tx_buf.push_back(8'h33);
        run_frame("m1_burst", 2'b01, 32);
        chk("m1/reg0", 64'(regs_flat[0 +: 8]), 64'h22);

        tx_buf.delete(); tx_buf.push_back(8'h82); tx_buf.push_back(8'h5C);
        run_frame("m2_abort", 2'b10, 13);
        tx_buf.delete(); tx_buf.push_back(8'h82); tx_buf.push_back(8'($urandom));
        run_frame("m2_next", 2'b10, 16);

        tx_buf.delete(); tx_buf.push_back(8'h8A); tx_buf.push_back(8'hFF);
        run_frame("bad_wr", 2'b00, 16);
        tx_buf.delete(); tx_buf.push_back(8'h0A); tx_buf.push_back(8'h00); tx_buf.push_back(8'h00);
        run_frame("bad_rd", 2'b01, 24);

        for (int f = 0; f < 16; f++) begin
            m   = 2'($urandom_range(0, 3));
            len = $urandom_range(0, 3);
            cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15))};
            tx_buf.delete();
            tx_buf.push_back(cmd);
            for (int k = 0; k < len; k++) tx_buf.push_back(8'($urandom));
            run_frame("rand", m, 8 * (len + 1));
        end

        tx_buf.delete(); tx_buf.push_back(8'h81); tx_buf.push_back(8'h5A);
        run_frame("pre_rst", 2'b00, 16);

        tx_buf.delete(); tx_buf.push_back(8'h85); tx_buf.push_back(8'h3C);
        wbase = wr_log.size();
        dbase = done_cnt;
        ebase = err_cnt;
        fork
            spi_frame(2'b00, 16);
            begin
                #(26*H);
                reset = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                chk("mid_rst/regs", regs_flat, 64'h0);
                chk("mid_rst/miso_oe", 64'(miso_oe), 64'h0);
                reset = 1'b1;
                repeat (4) @(posedge clk);
                #2;
                chk("post_rst/miso_oe", 64'(miso_oe), 64'h0);
            end
        join
        foreach (exp_regs[i]) exp_regs[i] = 8'h00;
        chk("post_rst/regs", regs_flat, 64'h0);
        chk("post_rst/wr_cnt", 64'(wr_log.size() - wbase), 64'h0);
        chk("post_rst/done", 64'(done_cnt - dbase), 64'h0);
        chk("post_rst/err", 64'(err_cnt - ebase), 64'h0);

        tx_buf.delete(); tx_buf.push_back(8'h84); tx_buf.push_back(8'hC3);
        run_frame("after_rst", 2'b00, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
